char_buf_16x16_writer: RTL and testbench

Writable 16x16 character buffer: the write-side counterpart of the fixed-text char ROMs. It accepts a stream of character and control commands over a valid/ready handshake, keeps a cursor, and stores 7-bit character codes in a 256-entry RAM. The drawing pipeline reads the RAM through the same `char_xy` → `char_code` lookup that the ROMs provide, so it can show dynamic text such as scores, names and messages. Only read latency differs.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/char_ram_256x7.sv | 34 +++
 rtl/char_buf_16x16_writer.sv | 109 ++++++++++
 tb/tb_char_buf_16x16_writer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA text-mode definitions: character codes, buffer geometry and the
// command/state encodings used by the writable character buffer.
package vga_pkg;

   localparam logic [6:0] Spc = 7'h20;
   localparam logic [6:0] A   = 7'h41;
   localparam logic [6:0] G   = 7'h47;
   localparam logic [6:0] Q   = 7'h51;
   localparam logic [6:0] X   = 7'h58;
   localparam logic [6:0] Z   = 7'h5A;

   localparam int CHAR_BUF_COLS  = 16;
   localparam int CHAR_BUF_ROWS  = 16;
   localparam int CHAR_BUF_CELLS = CHAR_BUF_COLS * CHAR_BUF_ROWS;

   typedef enum logic [1:0] {
      CMD_CHAR = 2'd0,
      CMD_NL   = 2'd1,
      CMD_BS   = 2'd2,
      CMD_CLR  = 2'd3
   } char_cmd_t;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } char_buf_state_t;

endpackage

// File: rtl/char_ram_256x7.sv
// 256x7 simple dual-port RAM: synchronous write, registered read-first read.
module char_ram_256x7
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_we,
   input  logic [7:0] i_waddr,
   input  logic [6:0] i_wdata,
   input  logic [7:0] i_raddr,
   output logic [6:0] o_rdata
);

   logic [6:0] r_mem [0:CHAR_BUF_CELLS-1];
   logic [6:0] r_rdata;

   // Array has no reset so it can map onto RAM primitives
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= 7'h00;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/char_buf_16x16_writer.sv
// Writable 16x16 character buffer: command stream in, cursor tracking,
// clear sweep after reset/CMD_CLR, independent registered read port.
module char_buf_16x16_writer
   import vga_pkg::*;
#(
   parameter logic [6:0] CLEAR_CODE = Spc
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  char_cmd_t  in_cmd,
   input  logic [6:0] in_char,
   input  logic [7:0] char_xy,
   output logic [6:0] char_code,
   output logic [7:0] cursor_xy,
   output logic       busy
);

   char_buf_state_t r_state;
   char_buf_state_t w_state_nxt;
   logic [7:0]      r_sweep;
   logic [7:0]      w_sweep_nxt;
   logic [7:0]      r_cursor;
   logic [7:0]      w_cursor_nxt;
   logic            w_we;
   logic [7:0]      w_waddr;
   logic [6:0]      w_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_CLEAR;
         r_sweep  <= 8'h00;
         r_cursor <= 8'h00;
      end else begin
         r_state  <= w_state_nxt;
         r_sweep  <= w_sweep_nxt;
         r_cursor <= w_cursor_nxt;
      end
   end

   // Sweep counter is parked at zero in IDLE so CMD_CLR always restarts at 0x00
   always_comb begin
      w_state_nxt  = r_state;
      w_sweep_nxt  = r_sweep;
      w_cursor_nxt = r_cursor;
      w_we         = 1'b0;
      w_waddr      = r_cursor;
      w_wdata      = in_char;
      case (r_state)
         ST_CLEAR: begin
            w_we        = 1'b1;
            w_waddr     = r_sweep;
            w_wdata     = CLEAR_CODE;
            w_sweep_nxt = r_sweep + 8'd1;
            if (r_sweep == 8'hFF) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            w_sweep_nxt = 8'h00;
            if (in_valid) begin
               case (in_cmd)
                  CMD_CHAR: begin
                     w_we         = 1'b1;
                     w_cursor_nxt = r_cursor + 8'd1;
                  end
                  CMD_NL: begin
                     w_cursor_nxt = {r_cursor[7:4] + 4'd1, 4'h0};
                  end
                  CMD_BS: begin
                     if (r_cursor != 8'h00) begin
                        w_we         = 1'b1;
                        w_waddr      = r_cursor - 8'd1;
                        w_wdata      = CLEAR_CODE;
                        w_cursor_nxt = r_cursor - 8'd1;
                     end
                  end
                  CMD_CLR: begin
                     w_cursor_nxt = 8'h00;
                     w_state_nxt  = ST_CLEAR;
                  end
                  default: begin
                  end
               endcase
            end
         end
         default: begin
            w_state_nxt = ST_CLEAR;
         end
      endcase
   end

   char_ram_256x7 u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (char_xy),
      .o_rdata (char_code)
   );

   assign in_ready  = (r_state == ST_IDLE);
   assign busy      = (r_state == ST_CLEAR);
   assign cursor_xy = r_cursor;

endmodule

// File: tb/tb_char_buf_16x16_writer.sv
// Randomized scoreboard bench for char_buf_16x16_writer against a cell-level
// model of the buffer, cursor and clear sweep.
module tb_char_buf_16x16_writer;
   import vga_pkg::*;

   localparam logic [6:0] CLR_CODE = Spc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   char_cmd_t  in_cmd = CMD_CHAR;
   logic [6:0] in_char = 7'h00;
   logic [7:0] char_xy = 8'h00;
   logic [6:0] char_code;
   logic [7:0] cursor_xy;
   logic       busy;

   typedef struct {
      int         due;
      int         kind;
      logic [7:0] val;
   } expect_t;

   expect_t    sbQ[$];
   expect_t    monItem;
   int         edgeCount = 0;
   int         assertCount = 0;
   int         failCount = 0;

   logic [6:0] mem [256];
   bit         memKnown [256];
   int         cursor = 0;
   int         sweepLeft = 0;

   char_buf_16x16_writer #(.CLEAR_CODE(CLR_CODE)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_cmd    (in_cmd),
      .in_char   (in_char),
      .char_xy   (char_xy),
      .char_code (char_code),
      .cursor_xy (cursor_xy),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCount <= edgeCount + 1;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s at edge %0d: got 0x%0h, required 0x%0h", name, edgeCount, act, exp);
      end
   endtask

   // Monitor drains every expectation that has come due by this falling edge
   always @(negedge clk) begin
      while (sbQ.size() > 0 && sbQ[0].due <= edgeCount) begin
         monItem = sbQ.pop_front();
         case (monItem.kind)
            0:       checkOutput("char_code", {1'b0, char_code}, monItem.val);
            1:       checkOutput("cursor_xy", cursor_xy, monItem.val);
            2:       checkOutput("in_ready", {7'h00, in_ready}, monItem.val);
            default: checkOutput("busy", {7'h00, busy}, monItem.val);
         endcase
      end
   end

   task automatic pushExp(input int due, input int kind, input logic [7:0] val);
      expect_t e;
      e.due  = due;
      e.kind = kind;
      e.val  = val;
      sbQ.push_back(e);
   endtask

   task automatic waitEdge();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Drives one cycle of inputs, advances the model across the coming edge
   task automatic applyStimulus(input logic v, input char_cmd_t c, input logic [6:0] ch,
                                input logic [7:0] xy, input bit doRead);
      int due;
      in_valid = v;
      in_cmd   = c;
      in_char  = ch;
      char_xy  = xy;
      due      = edgeCount + 1;
      if (doRead && memKnown[xy]) pushExp(due, 0, {1'b0, mem[xy]});
      if (sweepLeft > 0) begin
         mem[256 - sweepLeft]      = CLR_CODE;
         memKnown[256 - sweepLeft] = 1'b1;
         sweepLeft--;
      end else if (v) begin
         case (c)
            CMD_CHAR: begin
               mem[cursor]      = ch;
               memKnown[cursor] = 1'b1;
               cursor           = (cursor + 1) % 256;
            end
            CMD_NL: cursor = ((cursor / 16 + 1) % 16) * 16;
            CMD_BS: begin
               if (cursor != 0) begin
                  cursor           = cursor - 1;
                  mem[cursor]      = CLR_CODE;
                  memKnown[cursor] = 1'b1;
               end
            end
            default: begin
               cursor    = 0;
               sweepLeft = 256;
            end
         endcase
      end
      pushExp(due, 1, 8'(cursor));
      pushExp(due, 2, {7'h00, sweepLeft == 0});
      pushExp(due, 3, {7'h00, sweepLeft != 0});
      waitEdge();
   endtask

   task automatic applyReset(input int n);
      rst      = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         pushExp(edgeCount + 1, 0, 8'h00);
         pushExp(edgeCount + 1, 1, 8'h00);
         pushExp(edgeCount + 1, 2, 8'h00);
         pushExp(edgeCount + 1, 3, 8'h01);
         waitEdge();
      end
      rst       = 1'b0;
      cursor    = 0;
      sweepLeft = 256;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, CMD_CHAR, 7'h00, 8'h00, 1'b0);
   endtask

   task automatic sendCmd(input char_cmd_t c, input logic [6:0] ch);
      applyStimulus(1'b1, c, ch, 8'h00, 1'b0);
   endtask

   task automatic readAddr(input logic [7:0] xy);
      applyStimulus(1'b0, CMD_CHAR, 7'h00, xy, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0]  xy;
      int          r;
      char_cmd_t   c;
      for (int i = 0; i < 256; i++) memKnown[i] = 1'b0;

      applyReset(5);
      idle(10);
      readAddr(8'h00);
      idle(245);
      readAddr(8'h00);
      readAddr(8'h7F);
      readAddr(8'hFF);

      sendCmd(CMD_CHAR, Z);
      sendCmd(CMD_CHAR, A);
      sendCmd(CMD_CHAR, G);
      for (int i = 0; i < 4; i++) readAddr(8'(i));

      sendCmd(CMD_NL, 7'h00);
      sendCmd(CMD_NL, 7'h00);
      for (int i = 0; i < 5; i++) sendCmd(CMD_CHAR, 7'(7'h30 + i));
      sendCmd(CMD_NL, 7'h00);
      for (int i = 0; i < 12; i++) sendCmd(CMD_NL, 7'h00);
      for (int i = 0; i < 7; i++) sendCmd(CMD_CHAR, 7'(7'h61 + i));
      sendCmd(CMD_NL, 7'h00);
      for (int i = 0; i < 15; i++) sendCmd(CMD_NL, 7'h00);
      for (int i = 0; i < 15; i++) sendCmd(CMD_CHAR, 7'(7'h41 + i));
      sendCmd(CMD_CHAR, X);
      readAddr(8'hFF);

      readAddr(8'h00);
      sendCmd(CMD_BS, 7'h00);
      readAddr(8'h00);
      sendCmd(CMD_NL, 7'h00);
      sendCmd(CMD_CHAR, Q);
      readAddr(8'h10);
      sendCmd(CMD_BS, 7'h00);
      readAddr(8'h10);

      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      c = CMD_CHAR;
         else if (r < 80) c = CMD_NL;
         else if (r < 97) c = CMD_BS;
         else             c = CMD_CLR;
         applyStimulus($urandom_range(0, 3) != 0, c, 7'($urandom_range(0, 127)),
                       8'($urandom_range(0, 255)), 1'b1);
      end
      idle(260);

      for (int i = 0; i < 5; i++) sendCmd(CMD_CHAR, 7'($urandom_range(33, 126)));
      sendCmd(CMD_CLR, 7'h00);
      idle(256);
      for (int i = 0; i < 256; i++) readAddr(8'(i));

      for (int i = 0; i < 20; i++) sendCmd(CMD_CHAR, 7'($urandom_range(0, 127)));

      xy = 8'(cursor);
      applyStimulus(1'b1, CMD_CHAR, X, xy, 1'b1);
      readAddr(xy);

      sendCmd(CMD_CLR, 7'h00);
      idle(99);
      applyReset(3);
      idle(260);
      readAddr(8'h00);
      readAddr(8'hFF);

      idle(2);
      if (sbQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sbQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
